// File: rtl/vs_fp_dot_acc.sv
// rtl/vs_fp_dot_acc.sv - streaming Q-format dot-product accumulator with saturated 32-bit result
// Optional macro VS_FP_DOT_ACC_ROUND_EN: round each product to nearest before the Q shift.

module vs_fp_dot_acc #(
  parameter int Q     = 15,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [LEN_W-1:0] out_len,
  output logic             out_sat
);

  typedef enum logic [1:0] {ACCUM, DRAIN, OUT} state_t;
  state_t state, state_next;

  localparam logic signed [63:0] MAX_V    = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [63:0] MIN_V    = -MAX_V;
  localparam logic [LEN_W-1:0]   FORCE_AT = {{(LEN_W-1){1'b1}}, 1'b0};

  logic signed [63:0] a_ext, b_ext, prod, prod_q, p, acc, sum;
  logic               p_valid, p_last, accept, last_eff;
  logic [LEN_W-1:0]   count, seen;

  assign a_ext = {{32{a[31]}}, a};
  assign b_ext = {{32{b[31]}}, b};
  assign prod  = a_ext * b_ext;

`ifdef VS_FP_DOT_ACC_ROUND_EN
  assign prod_q = (prod + (64'sd1 <<< (Q-1))) >>> Q;
`else
  assign prod_q = prod >>> Q;
`endif

  // Elements accepted so far include the product still sitting in stage 1.
  assign seen     = count + LEN_W'(p_valid);
  assign last_eff = in_last || (seen == FORCE_AT);
  assign accept   = in_valid && in_ready;
  assign sum      = acc + p;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ACCUM;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && last_eff) state_next = DRAIN;
      end
      DRAIN: state_next = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p        <= '0;
      p_valid  <= 1'b0;
      p_last   <= 1'b0;
      acc      <= '0;
      count    <= '0;
      out_data <= '0;
      out_len  <= '0;
      out_sat  <= 1'b0;
    end else begin
      p_valid <= accept;
      if (accept) begin
        p      <= prod_q;
        p_last <= last_eff;
      end
      if (p_valid) begin
        if (p_last) begin
          // Symmetric clamp keeps 32'h80000000 out of the result.
          if (sum > MAX_V) begin
            out_data <= MAX_V[31:0];
            out_sat  <= 1'b1;
          end else if (sum < MIN_V) begin
            out_data <= MIN_V[31:0];
            out_sat  <= 1'b1;
          end else begin
            out_data <= sum[31:0];
            out_sat  <= 1'b0;
          end
          out_len <= count + LEN_W'(1);
          acc     <= '0;
          count   <= '0;
        end else begin
          acc   <= sum;
          count <= count + LEN_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vs_fp_dot_acc.sv
// tb/tb_vs_fp_dot_acc.sv - directed scoreboard bench for vs_fp_dot_acc

module tb_vs_fp_dot_acc;

  localparam int Q = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_last;
  logic [31:0] a, b;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [15:0] out_len;
  logic        out_sat;

  typedef struct {
    logic [31:0] data;
    logic [15:0] len;
    logic        sat;
  } exp_t;

  exp_t   sbq[$];
  longint m_acc = 0;
  int     m_len = 0;
  int     checks = 0;
  int     failures = 0;

  vs_fp_dot_acc #(.Q(Q), .LEN_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_len(out_len), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint prod_model(input logic [31:0] x, input logic [31:0] y);
    longint px, py, pr;
    px = longint'($signed(x));
    py = longint'($signed(y));
    pr = px * py;
`ifdef VS_FP_DOT_ACC_ROUND_EN
    pr = pr + (64'sd1 <<< (Q-1));
`endif
    return pr >>> Q;
  endfunction

  task automatic model_add(input logic [31:0] x, input logic [31:0] y, input logic last);
    exp_t e;
    m_acc += prod_model(x, y);
    m_len++;
    if (last) begin
      if (m_acc > 64'sd2147483647) begin
        e.data = 32'h7FFF_FFFF; e.sat = 1'b1;
      end else if (m_acc < -64'sd2147483647) begin
        e.data = 32'h8000_0001; e.sat = 1'b1;
      end else begin
        e.data = m_acc[31:0];   e.sat = 1'b0;
      end
      e.len = m_len[15:0];
      sbq.push_back(e);
      m_acc = 0;
      m_len = 0;
    end
  endtask

  task automatic push(input logic [31:0] x, input logic [31:0] y, input logic last);
    in_valid = 1'b1; a = x; b = y; in_last = last;
    check("in_ready_on_push", in_ready, 1);
    model_add(x, y, last);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Called in cycle t+1 after the last element; holds the result for 'hold' cycles.
  task automatic collect(input int hold);
    exp_t e;
    int   w;
    check("out_valid_t1", out_valid, 0);
    check("in_ready_drain", in_ready, 0);
    tick();
    check("out_valid_t2", out_valid, 1);
    w = 0;
    while (out_valid !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    if (sbq.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
      return;
    end
    e = sbq.pop_front();
    check("out_data", out_data, e.data);
    check("out_len", out_len, e.len);
    check("out_sat", out_sat, e.sat);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = 32'd5; b = 32'd5; in_last = 1'b0;
      check("in_ready_blocked", in_ready, 0);
      tick();
      check("out_valid_held", out_valid, 1);
      check("out_data_held", out_data, e.data);
      check("out_len_held", out_len, e.len);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_cleared", out_valid, 0);
    check("in_ready_return", in_ready, 1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_len", out_len, 0);
    check("rst_out_sat", out_sat, 0);
    reset = 1'b0;
    tick();
    check("in_ready_after_rst", in_ready, 1);

    // 1.0 * 1.0, single element
    push(32'd32768, 32'd32768, 1'b1);
    collect(0);

    // four back-to-back 0.5*0.5
    for (int i = 0; i < 4; i++) push(32'd16384, 32'd16384, i == 3);
    collect(0);

    // -1 * 1 LSB: floor vs round
    push(32'hFFFF_FFFF, 32'd1, 1'b1);
    collect(0);

    // positive and negative saturation
    push(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
    collect(0);
    push(32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    collect(0);

    // mixed-sign random vector
    for (int i = 0; i < 6; i++) begin
      int ra, rb;
      ra = int'($urandom_range(0, 2097151)) - 1048576;
      rb = int'($urandom_range(0, 2097151)) - 1048576;
      push(ra, rb, i == 5);
    end
    collect(0);

    // backpressure with upstream valid held high
    push(32'd32768, 32'd32768, 1'b1);
    collect(5);
    push(32'd32768, 32'd32768, 1'b1);
    collect(0);

    // asynchronous reset mid-vector
    push(32'd32768, 32'd32768, 1'b0);
    push(32'd32768, 32'd32768, 1'b0);
    #2 reset = 1'b1;
    #1;
    m_acc = 0;
    m_len = 0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_len", out_len, 0);
    check("midrst_out_sat", out_sat, 0);
    tick();
    reset = 1'b0;
    tick();
    push(32'd32768, 32'd32768, 1'b1);
    collect(0);

    check("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
